// File: rtl/screen_scanner_if.sv
// Read-only screen RAM port between the scanner (master) and the screen memory (slave).
// Read data is valid one clk after ram_addr/ram_rd are registered.
interface screen_scanner_if;
    logic [12:0] ram_addr;
    logic        ram_rd;
    logic [15:0] ram_data;

    modport master (
        output ram_addr,
        output ram_rd,
        input  ram_data
    );

    modport slave (
        input  ram_addr,
        input  ram_rd,
        output ram_data
    );
endinterface

// File: rtl/screen_scanner.sv
// Raster scanner for the 512x256 Hack screen: fetches screen words in raster order and
// serialises them LSB-first into a 1-bit pixel stream with sync/blank/de timing.
module screen_scanner #(
    parameter int unsigned H_FP   = 16,
    parameter int unsigned H_SYNC = 64,
    parameter int unsigned H_BP   = 48,
    parameter int unsigned V_FP   = 3,
    parameter int unsigned V_SYNC = 4,
    parameter int unsigned V_BP   = 25
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ce_pix,
    screen_scanner_if.master  ram,
    output logic              pixel,
    output logic              de,
    output logic              hblank,
    output logic              vblank,
    output logic              hsync,
    output logic              vsync
);
    localparam int unsigned H_ACTIVE = 512;
    localparam int unsigned V_ACTIVE = 256;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW       = $clog2(H_TOTAL);
    localparam int unsigned VW       = $clog2(V_TOTAL);
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    logic [HW-1:0] h, h_n;
    logic [VW-1:0] v, v_n, v_row;
    logic [15:0]   shifter, hold;
    logic          de_n, hsync_n, vsync_n;
    logic          fetch_mid, fetch_first;
    logic [12:0]   fetch_addr;

    // Next raster position; every registered output is derived from it.
    always_comb begin
        h_n = h + HW'(1);
        v_n = v;
        if (h == HW'(H_TOTAL - 1)) begin
            h_n = '0;
            v_n = (v == VW'(V_TOTAL - 1)) ? '0 : v + VW'(1);
        end
        v_row = (v_n == VW'(V_TOTAL - 1)) ? '0 : v_n + VW'(1);

        de_n    = (h_n < HW'(H_ACTIVE)) && (v_n < VW'(V_ACTIVE));
        hsync_n = !((h_n >= HW'(HS_START)) && (h_n < HW'(HS_END)));
        vsync_n = !((v_n >= VW'(VS_START)) && (v_n < VW'(VS_END)));

        // Each word is requested 3 ticks before its first pixel; word 0 of a row is
        // requested at the tail of the previous line.
        fetch_mid   = (h_n < HW'(H_ACTIVE)) && (h_n[3:0] == 4'd13) &&
                      (h_n[8:4] != 5'd31) && (v_n < VW'(V_ACTIVE));
        fetch_first = (h_n == HW'(H_TOTAL - 3)) && (v_row < VW'(V_ACTIVE));
        fetch_addr  = fetch_mid ? {v_n[7:0], h_n[8:4] + 5'd1} : {v_row[7:0], 5'd0};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h            <= HW'(H_ACTIVE);
            v            <= VW'(V_TOTAL - 1);
            pixel        <= 1'b0;
            de           <= 1'b0;
            hblank       <= 1'b1;
            vblank       <= 1'b1;
            hsync        <= 1'b1;
            vsync        <= 1'b1;
            ram.ram_addr <= '0;
            ram.ram_rd   <= 1'b0;
            shifter      <= '0;
            hold         <= '0;
        end else begin
            ram.ram_rd <= 1'b0;
            // Capture is tied to the strobe, not to ce_pix, so any pixel rate works.
            if (ram.ram_rd) begin
                hold <= ram.ram_data;
            end
            if (ce_pix) begin
                h      <= h_n;
                v      <= v_n;
                de     <= de_n;
                hblank <= (h_n >= HW'(H_ACTIVE));
                vblank <= (v_n >= VW'(V_ACTIVE));
                hsync  <= hsync_n;
                vsync  <= vsync_n;
                if (fetch_mid || fetch_first) begin
                    ram.ram_addr <= fetch_addr;
                    ram.ram_rd   <= 1'b1;
                end
                if (!de_n) begin
                    pixel <= 1'b0;
                end else if (h_n[3:0] == 4'd0) begin
                    pixel   <= hold[0];
                    shifter <= {1'b0, hold[15:1]};
                end else begin
                    pixel   <= shifter[0];
                    shifter <= {1'b0, shifter[15:1]};
                end
            end
        end
    end
endmodule

// File: tb/tb_screen_scanner.sv
// Scoreboard bench for screen_scanner: a driver pushes expected per-tick video and fetch
// results from a raster-position model; a monitor pops and compares after each tick.
module tb_screen_scanner;
    localparam int unsigned H_TOTAL = 640;
    localparam int unsigned V_TOTAL = 288;
    localparam int unsigned FRAME   = H_TOTAL * V_TOTAL;
    localparam int unsigned START   = (V_TOTAL - 1) * H_TOTAL + 512;

    typedef struct {
        int unsigned t;
        int unsigned h;
        int unsigned v;
        logic [5:0]  vid;
        logic        rd;
        logic [12:0] addr;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic ce_pix = 1'b0;
    logic pixel, de, hblank, vblank, hsync, vsync;

    screen_scanner_if bus();

    screen_scanner dut (
        .clk     (clk),
        .reset_n (reset_n),
        .ce_pix  (ce_pix),
        .ram     (bus),
        .pixel   (pixel),
        .de      (de),
        .hblank  (hblank),
        .vblank  (vblank),
        .hsync   (hsync),
        .vsync   (vsync)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [8192];
    exp_t        exp_q[$];
    int unsigned t_model;
    int          total = 0;
    int          bad = 0;

    // Row-0 / row-1 observation counters, cleared by the driver.
    int          ones_row0, xsum_row0, de_row1, hs_low_row1, hs_first_row1, first_rd_t;
    logic [12:0] first_rd_addr;

    // Screen RAM: data valid during the clk after the strobe, junk otherwise.
    always @(negedge clk) begin
        if (bus.ram_rd) bus.ram_data = mem[bus.ram_addr];
        else            bus.ram_data = 16'($urandom);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input int unsigned tt);
        exp_t        e;
        int unsigned p, q, hq, vq;
        logic [15:0] w;
        p    = (START + tt) % FRAME;
        e.t  = tt;
        e.h  = p % H_TOTAL;
        e.v  = p / H_TOTAL;
        w    = (e.h < 512 && e.v < 256) ? mem[e.v * 32 + e.h / 16] : 16'h0;
        e.vid = {(e.h < 512 && e.v < 256) ? w[e.h % 16] : 1'b0,
                 e.h < 512 && e.v < 256, e.h >= 512, e.v >= 256,
                 !(e.h >= 528 && e.h < 592), !(e.v >= 259 && e.v < 263)};
        // A word is requested 3 ticks before the position where it is first shown.
        q  = (p + 3) % FRAME;
        hq = q % H_TOTAL;
        vq = q / H_TOTAL;
        e.rd   = (hq < 512) && (hq % 16 == 0) && (vq < 256);
        e.addr = e.rd ? 13'(vq * 32 + hq / 16) : 13'd0;
        return e;
    endfunction

    always @(posedge clk) begin : monitor
        logic tk;
        exp_t e;
        tk = ce_pix && reset_n;
        #1;
        if (tk) begin
            if (exp_q.size() == 0) begin
                chk("queue_underflow", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk($sformatf("video t=%0d h=%0d v=%0d", e.t, e.h, e.v),
                    {pixel, de, hblank, vblank, hsync, vsync}, e.vid);
                chk($sformatf("ram_rd t=%0d", e.t), bus.ram_rd, e.rd);
                if (e.rd && bus.ram_rd)
                    chk($sformatf("ram_addr t=%0d", e.t), bus.ram_addr, e.addr);
                if (bus.ram_rd && first_rd_t < 0) begin
                    first_rd_t    = e.t;
                    first_rd_addr = bus.ram_addr;
                end
                if (e.v == 0 && pixel) begin
                    ones_row0++;
                    xsum_row0 += e.h;
                end
                if (e.v == 1 && de) de_row1++;
                if (e.v == 1 && !hsync) begin
                    if (hs_low_row1 == 0) hs_first_row1 = e.h;
                    hs_low_row1++;
                end
            end
        end else if (reset_n) begin
            chk("ram_rd_idle", bus.ram_rd, 1'b0);
        end
    end

    task automatic clear_obs();
        ones_row0 = 0; xsum_row0 = 0; de_row1 = 0;
        hs_low_row1 = 0; hs_first_row1 = -1; first_rd_t = -1; first_rd_addr = '1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_video"}, {pixel, de, hblank, vblank, hsync, vsync}, 6'b001111);
        chk({tag, "_ram_addr"}, bus.ram_addr, 13'd0);
        chk({tag, "_ram_rd"}, bus.ram_rd, 1'b0);
        chk({tag, "_hold"}, dut.hold, 16'd0);
        chk({tag, "_shifter"}, dut.shifter, 16'd0);
        chk({tag, "_h"}, 32'(dut.h), 32'd512);
        chk({tag, "_v"}, 32'(dut.v), V_TOTAL - 1);
    endtask

    task automatic release_reset();
        exp_q.delete();
        t_model = 0;
        clear_obs();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Issue 'ticks' ticks with ce_pix high on every div-th clk.
    task automatic run(input int ticks, input int div);
        int c = 0;
        int done = 0;
        while (done < ticks) begin
            @(negedge clk);
            ce_pix = (c % div) == 0;
            c++;
            if (ce_pix) begin
                t_model++;
                exp_q.push_back(model(t_model));
                done++;
            end
        end
        @(negedge clk);
        ce_pix = 1'b0;
    endtask

    initial begin
        bit got_rd;
        for (int i = 0; i < 8192; i++) mem[i] = 16'h0;
        mem[0] = 16'h0001;
        mem[1] = 16'h8000;
        clear_obs();

        // Phase 1: reset values, first fetch timing, row-0 pattern, line timing.
        #12;
        check_reset("por");
        release_reset();
        run(125 + 3 * 640, 1);
        chk("first_rd_tick", first_rd_t, 125);
        chk("first_rd_addr", first_rd_addr, 13'd0);
        chk("row0_ones", ones_row0, 2);
        chk("row0_xsum", xsum_row0, 31);
        chk("row1_de_count", de_row1, 512);
        chk("row1_hsync_low", hs_low_row1, 64);
        chk("row1_hsync_first", hs_first_row1, 528);

        // Phase 2: asynchronous reset mid-frame, then random contents at ce_pix 1-in-4.
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1 check_reset("midline");
        for (int i = 0; i < 8192; i++) mem[i] = 16'($urandom);
        repeat (3) @(posedge clk);
        release_reset();
        run(125 + 12 * 640, 4);
        chk("row1_de_count_ce4", de_row1, 512);

        // Phase 3: reset on the very clk ram_rd is high; the capture must be dropped.
        got_rd = 1'b0;
        for (int i = 0; i < 1000 && !got_rd; i++) begin
            @(negedge clk);
            ce_pix = 1'b1;
            t_model++;
            exp_q.push_back(model(t_model));
            @(posedge clk);
            #2 got_rd = bus.ram_rd;
        end
        chk("midfetch_rd_seen", got_rd, 1'b1);
        reset_n = 1'b0;
        #1 check_reset("midfetch");
        @(posedge clk);
        #1 chk("midfetch_hold_after_edge", dut.hold, 16'd0);
        ce_pix = 1'b0;
        release_reset();
        run(125 + 40 * 640, 1);
        chk("row1_de_count_restart", de_row1, 512);
        chk("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
